pipe_credit_buffer: RTL and testbench
=====================================

# pipe_credit_buffer

Elastic output buffer with credit-based issue control that consumes the output of a fixed-latency delay line (non-stallable `pipeline` chain, modular arithmetic units). Fixed-latency pipelines cannot be back-pressured. This block therefore grants launch permission only when buffer space is guaranteed for every in-flight item. It absorbs the pipeline output and presents it to a downstream valid/ready consumer.

## Interface
- `BIT_WIDTH`, default `` `BIT_WIDTH ``: data word width.
- `DEPTH`, default 8: buffer entries. Must be a power of 2 and ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of occupancy and in-flight counters (derived, not overridden).
- Reset `rst_n`: synchronous, active-low. Clock `clk`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `issue_valid` in 1: upstream requests to launch one item into the pipeline.
- `issue_ready` out 1: launch permitted this cycle. Issue fires when `issue_valid && issue_ready`.
- `in_valid` in 1: pipeline output valid (launched item arriving).
- `in_data` in BIT_WIDTH: pipeline output data.
- `out_valid` out 1: buffer head valid.
- `out_data` out BIT_WIDTH: buffer head data.
- `out_ready` in 1: downstream accepts head. Pop fires when `out_valid && out_ready`.
- `occupancy` out CNT_W: entries currently stored.
- `inflight` out CNT_W: issued items not yet arrived.
- `err` out 1: sticky protocol error flag.

## Operation
- Storage: DEPTH-entry circular RAM with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH. Read is show-ahead: `out_data = mem[rp]`.
- `issue_ready = (occupancy + inflight) < DEPTH`. It is computed from registered values only, with no combinational path from `issue_valid`, `in_valid` or `out_ready`.
- `inflight` next value = `inflight + issue_fire − in_valid_accepted`. An issue fire and an arrival in the same cycle leave it unchanged.
- `occupancy` next value = `occupancy + push − pop`. Push and pop in the same cycle leave it unchanged, and both pointers advance.
- Push occurs when `in_valid` and the buffer is not full, or when it is full and a pop fires the same cycle. Data is written at `wp`.
- `out_valid = (occupancy != 0)`.
- Error conditions all set `err`, which stays at 1 until reset:
  - (a) `in_valid` while the buffer is full and no pop fires. The word is dropped and pointers and occupancy are unchanged.
  - (b) `in_valid` while `inflight == 0` (unsolicited arrival). The word is still pushed if space exists, and `inflight` saturates at 0.
  - (c) Pop of an empty buffer cannot occur, because pop requires `out_valid`.
- Counters never wrap. `inflight` saturates at 0 and at DEPTH.
- Block is latency-agnostic: any pipeline depth works. Throughput is 1 item/cycle when `DEPTH ≥ pipeline latency + 1` and `out_ready` is held at 1.

## Timing
- Reset values: `issue_ready=1`, `out_valid=0`, `out_data` = don't-care (the RAM is not reset), `occupancy=0`, `inflight=0`, `err=0`. Pointers are 0.
- Reset mid-operation clears all state in the same edge and discards buffered and in-flight accounting. The upstream pipeline valid chain must be reset by the same `rst_n`.
- Pushed data appears on `out_data`/`out_valid` the cycle after the push edge, so the minimum `in_valid`→`out_valid` latency is 1 cycle.
- `issue_ready` reflects state after each edge. A pop at edge N raises `issue_ready` from cycle N+1.
- When full (`occupancy == DEPTH`), a simultaneous push and pop is legal. Occupancy stays at DEPTH and no error is raised.
- When empty, a push makes `out_valid` high next cycle. There is no same-cycle bypass.

## Test plan
- Reset, then issue 8 items (DEPTH=8) through a 4-stage delay line with `out_ready=1` → 8 words out in order, 1/cycle after the first 5-cycle latency. `issue_ready` stays 1 and `err=0`.
- Hold `out_ready=0`, keep `issue_valid=1` → exactly 8 issue fires, then `issue_ready=0` while `occupancy+inflight=8`. Final `occupancy=8`, `inflight=0`.
- From full, raise `out_ready` for 1 cycle → one word popped. `issue_ready=1` the following cycle for exactly one issue.
- Full buffer, force `in_valid=1` with `out_ready=0` → word dropped, `err=1`, occupancy stays 8, `out_data` unchanged.
- Drive `in_valid=1` with `inflight=0` into an empty buffer → word output next cycle, `err=1`, `inflight` stays 0.
- Assert `rst_n=0` with 3 stored and 2 in flight → next cycle `occupancy=0`, `inflight=0`, `out_valid=0`, `issue_ready=1`, `err=0`.

Source files
------------

// File: rtl/pipe_credit_buffer.sv
// Elastic output buffer behind a fixed-latency, non-stallable pipeline, with credit-gated issue.
// Latency: 1 cycle from in_valid (push edge) to out_valid/out_data; no same-cycle bypass.
// Backpressure: out_ready stalls the head; issue_ready throttles launches so in-flight items always fit.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   issue_valid/issue_ready  launch handshake toward the pipeline entry
//   in_valid/in_data         pipeline output (cannot be stalled)
//   out_valid/out_data       buffer head toward the downstream consumer, out_ready accepts it
//   occupancy, inflight      stored entries and issued-but-not-arrived items
//   err                      sticky protocol error (overflow or unsolicited arrival)
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

module pipe_credit_buffer #(
   parameter int BIT_WIDTH = `BIT_WIDTH,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic                 in_valid,
   input  logic [BIT_WIDTH-1:0] in_data,
   output logic                 out_valid,
   output logic [BIT_WIDTH-1:0] out_data,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     occupancy,
   output logic [CNT_W-1:0]     inflight,
   output logic                 err
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [BIT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wp;
   logic [PTR_W-1:0]     rp;

   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 issue_fire;
   logic                 arrive;
   logic [CNT_W-1:0]     occ_d;
   logic [CNT_W-1:0]     inf_d;

   assign full       = (occupancy == DEPTH_C);
   assign out_valid  = (occupancy != '0);
   assign out_data   = mem[rp];
   assign pop        = out_valid && out_ready;
   // A full buffer can still accept when the head leaves in the same cycle.
   assign push       = in_valid && (!full || pop);

   // Only registered counters feed issue_ready; one extra bit keeps the sum from wrapping.
   assign issue_ready = ({1'b0, occupancy} + {1'b0, inflight}) < {1'b0, DEPTH_C};
   assign issue_fire  = issue_valid && issue_ready;

   // An arrival only retires a credit when one is outstanding; unsolicited words leave inflight at 0.
   assign arrive = in_valid && (inflight != '0);

   always_comb begin
      inf_d = inflight;
      if (issue_fire && !arrive) begin
         if (inflight != DEPTH_C) begin
            inf_d = inflight + ONE_C;
         end
      end else if (!issue_fire && arrive) begin
         inf_d = inflight - ONE_C;
      end
   end

   always_comb begin
      occ_d = occupancy;
      if (push && !pop) begin
         occ_d = occupancy + ONE_C;
      end else if (pop && !push) begin
         occ_d = occupancy - ONE_C;
      end
   end

   // Storage is not reset; out_data is meaningless while out_valid is low.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         occupancy <= '0;
         inflight  <= '0;
         err       <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + PTR_W'(1);
         end
         if (pop) begin
            rp <= rp + PTR_W'(1);
         end
         occupancy <= occ_d;
         inflight  <= inf_d;
         // Overflow drop, or a word nobody asked for.
         if ((in_valid && full && !pop) || (in_valid && (inflight == '0))) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_credit_buffer.sv
module tb_pipe_credit_buffer;

   localparam int W     = 32;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam int LAT   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] inflight;
   logic             err;

   always #5 clk = ~clk;

   pipe_credit_buffer #(.BIT_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy), .inflight(inflight), .err(err)
   );

   // Fixed-latency delay line feeding the buffer; force_* overrides its output.
   logic          force_en = 1'b0;
   logic          force_v  = 1'b0;
   logic [W-1:0]  force_d  = '0;
   logic [LAT-1:0] pv;
   logic [W-1:0]  pd [LAT];
   logic [W-1:0]  tag = '0;

   assign in_valid = force_en ? force_v : pv[LAT-1];
   assign in_data  = force_en ? force_d : pd[LAT-1];

   always @(posedge clk) begin
      if (!rst_n) pv <= '0;
      else        pv <= {pv[LAT-2:0], issue_valid && issue_ready};
      pd[0] <= tag;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      if (issue_valid && issue_ready) tag <= tag + 1;
   end

   int fires = 0;
   logic [W-1:0] got[$];
   always @(posedge clk) begin
      if (rst_n && issue_valid && issue_ready) fires++;
      if (rst_n && out_valid && out_ready) got.push_back(out_data);
   end

   // Reference model: a queue of stored words plus a credit count.
   logic [W-1:0] mq[$];
   int m_inf = 0;
   bit m_err = 1'b0;
   always @(posedge clk) begin : model
      bit fire, full, p;
      if (!rst_n) begin
         mq.delete();
         m_inf = 0;
         m_err = 1'b0;
      end else begin
         fire = issue_valid && ((mq.size() + m_inf) < DEPTH);
         full = (mq.size() == DEPTH);
         p    = (mq.size() != 0) && out_ready;
         if (in_valid && (m_inf == 0 || (full && !p))) m_err = 1'b1;
         if (p) mq.delete(0);
         if (in_valid && (!full || p)) mq.push_back(in_data);
         m_inf = m_inf + int'(fire) - int'(in_valid && m_inf > 0);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mcheck();
      chk("m_occ", 32'(occupancy), 32'(mq.size()));
      chk("m_inf", 32'(inflight), 32'(m_inf));
      chk("m_err", 32'(err), 32'(m_err));
      chk("m_ovld", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_irdy", 32'(issue_ready), 32'((mq.size() + m_inf) < DEPTH));
      if (mq.size() != 0) chk("m_data", out_data, mq[0]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mcheck();
   endtask

   task automatic do_reset();
      issue_valid = 1'b0; out_ready = 1'b0; force_en = 1'b0; force_v = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          rst;
      bit          iv;
      bit          fv;
      logic [31:0] fd;
      bit          ordy;
      int          occ;
      int          inf;
      bit          ov;
      bit          irdy;
      bit          er;
      logic [31:0] dat;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int first;
      bit rdy_drop;
      bit reached;
      logic [W-1:0] base;
      logic [W-1:0] head;

      //            rst iv fv fd       ordy occ inf ov irdy er dat
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 32'hA1, 1'b0, 1, 1, 1'b1, 1'b1, 1'b0, 32'hA1};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hA2, 1'b1, 1, 0, 1'b1, 1'b1, 1'b0, 32'hA2};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 32'hA2};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 32'hA3};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0};

      force_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         rst_n       = !tbl[i].rst;
         issue_valid = tbl[i].iv;
         force_v     = tbl[i].fv;
         force_d     = tbl[i].fd;
         out_ready   = tbl[i].ordy;
         step();
         chk($sformatf("t%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
         chk($sformatf("t%0d_inf", i), 32'(inflight), 32'(tbl[i].inf));
         chk($sformatf("t%0d_ovld", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("t%0d_irdy", i), 32'(issue_ready), 32'(tbl[i].irdy));
         chk($sformatf("t%0d_err", i), 32'(err), 32'(tbl[i].er));
         if (tbl[i].ov) chk($sformatf("t%0d_data", i), out_data, tbl[i].dat);
      end
      force_en = 1'b0; force_v = 1'b0;

      // 8 items through the delay line with the consumer always ready.
      do_reset();
      out_ready = 1'b1;
      got.delete();
      fires = 0;
      base = tag;
      first = -1;
      rdy_drop = 1'b0;
      issue_valid = 1'b1;
      for (int n = 1; n <= 40 && got.size() < 8; n++) begin
         step();
         if (out_valid && first < 0) first = n;
         if (!issue_ready) rdy_drop = 1'b1;
         issue_valid = (n < 8);
      end
      issue_valid = 1'b0;
      chk("s1_count", 32'(got.size()), 32'd8);
      chk("s1_latency", 32'(first), 32'd5);
      chk("s1_rdy_held", 32'(rdy_drop), 32'd0);
      chk("s1_err", 32'(err), 32'd0);
      chk("s1_fires", 32'(fires), 32'd8);
      for (int i = 0; i < got.size(); i++) chk($sformatf("s1_order%0d", i), got[i], base + W'(i));

      // Consumer stalled: credits run out after exactly DEPTH launches.
      out_ready = 1'b0;
      fires = 0;
      issue_valid = 1'b1;
      for (int n = 0; n < 20; n++) step();
      chk("s2_fires", 32'(fires), 32'd8);
      chk("s2_occ", 32'(occupancy), 32'd8);
      chk("s2_inf", 32'(inflight), 32'd0);
      chk("s2_irdy", 32'(issue_ready), 32'd0);

      // One pop frees exactly one credit.
      fires = 0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("s3_irdy_after_pop", 32'(issue_ready), 32'd1);
      for (int n = 0; n < 10; n++) step();
      issue_valid = 1'b0;
      chk("s3_fires", 32'(fires), 32'd1);
      chk("s3_occ", 32'(occupancy), 32'd8);

      // Overflow: arrival into a full, stalled buffer is dropped.
      head = mq[0];
      force_en = 1'b1; force_v = 1'b1; force_d = 32'hDEAD_BEEF;
      step();
      force_v = 1'b0; force_en = 1'b0;
      chk("s4_err", 32'(err), 32'd1);
      chk("s4_occ", 32'(occupancy), 32'd8);
      chk("s4_head", out_data, head);

      // Unsolicited arrival into an empty buffer.
      do_reset();
      force_en = 1'b1; force_v = 1'b1; force_d = 32'h0000_5A5A;
      step();
      force_v = 1'b0; force_en = 1'b0;
      chk("s5_ovld", 32'(out_valid), 32'd1);
      chk("s5_data", out_data, 32'h0000_5A5A);
      chk("s5_err", 32'(err), 32'd1);
      chk("s5_inf", 32'(inflight), 32'd0);

      // Reset with 3 stored and 2 still in the delay line.
      do_reset();
      issue_valid = 1'b1;
      for (int n = 0; n < 5; n++) step();
      issue_valid = 1'b0;
      reached = 1'b0;
      for (int n = 0; n < 20 && !reached; n++) begin
         if (mq.size() == 3) reached = 1'b1;
         else step();
      end
      chk("s6_reached", 32'(reached), 32'd1);
      chk("s6_inf_before", 32'(inflight), 32'd2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("s6_occ", 32'(occupancy), 32'd0);
      chk("s6_inf", 32'(inflight), 32'd0);
      chk("s6_ovld", 32'(out_valid), 32'd0);
      chk("s6_irdy", 32'(issue_ready), 32'd1);
      chk("s6_err", 32'(err), 32'd0);

      // Random traffic against the model; stall phases vary the consumer duty cycle.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         issue_valid = ($urandom_range(0, 3) != 0);
         if ((n / 200) % 2 == 0) out_ready = ($urandom_range(0, 1) != 0);
         else                    out_ready = ($urandom_range(0, 4) == 0);
         step();
      end
      chk("rnd_err", 32'(err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
